// File: rtl/wr_1000basex_pkg.sv
// Shared constants and types for the 1000BASE-X RX path.
// K-code values, sync FSM states and the legal-K check.
package wr_1000basex_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    ACQUIRE,
    SYNC_ACQ
  } t_rx_sync_state;

  // K28.0..K28.7 share low bits 5'h1C; the others are the /x.7 set
  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'h1C) ||
           (b == 8'hF7) || (b == 8'hFB) ||
           (b == 8'hFD) || (b == 8'hFE);
  endfunction

endpackage

// File: rtl/wr_1000basex_rx_sync_word_class.sv
// Combinational classifier for one decoded symbol pair.
// Flags bad words and good even-aligned commas.
module wr_1000basex_word_class
  import wr_1000basex_pkg::*;
(
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_k_i,
  input  logic        rx_enc_err_i,
  output logic        bad_o,
  output logic        good_comma_o
);

  logic odd_comma;
  logic even_illegal_k;

  // A comma in the odd byte means the stream is misaligned
  assign odd_comma      = rx_k_i[0] & (rx_data_i[7:0] == K28_5);
  assign even_illegal_k = rx_k_i[1] & !is_legal_k(rx_data_i[15:8]);

  assign bad_o = rx_enc_err_i | odd_comma | even_illegal_k;

  assign good_comma_o = !bad_o & rx_k_i[1] & !rx_k_i[0] &
                        (rx_data_i[15:8] == K28_5);

endmodule

// File: rtl/wr_1000basex_rx_sync.sv
// 1000BASE-X RX synchronization FSM with registered data forwarding.
// Define WR_RX_SYNC_STATS_EN to add bad-word / sync-loss counters.
module wr_1000basex_rx_sync
  import wr_1000basex_pkg::*;
#(
  parameter int g_comma_count  = 3,
  parameter int g_good_recover = 4,
  parameter int g_bad_limit    = 3
) (
  input  logic        clk_ref_i,
  input  logic        rst_i,
  input  logic [15:0] rx_data_i,
  input  logic [1:0]  rx_k_i,
  input  logic        rx_enc_err_i,
  output logic [15:0] rx_data_o,
  output logic [1:0]  rx_k_o,
  output logic        rx_valid_o,
  output logic        synced_o,
  output logic        sync_lost_p_o
`ifdef WR_RX_SYNC_STATS_EN
  ,
  output logic [15:0] bad_cnt_o,
  output logic [15:0] los_cnt_o
`endif
);

  localparam int AW = $clog2(g_comma_count + 1);
  localparam int GW = $clog2(g_good_recover + 1);
  localparam int SW = $clog2(g_bad_limit + 1);

  logic bad;
  logic good_comma;

  wr_1000basex_word_class u_class (
    .rx_data_i    (rx_data_i),
    .rx_k_i       (rx_k_i),
    .rx_enc_err_i (rx_enc_err_i),
    .bad_o        (bad),
    .good_comma_o (good_comma)
  );

  t_rx_sync_state state_q, state_d;
  logic [AW-1:0]  acq_cnt_q, acq_cnt_d;
  logic [GW-1:0]  good_cnt_q, good_cnt_d;
  logic [SW-1:0]  step_q, step_d;
  logic [AW-1:0]  acq_inc;
  logic [GW-1:0]  good_inc;
  logic           lost;

  logic [15:0] rx_data_q;
  logic [1:0]  rx_k_q;
  logic        valid_q;
  logic        synced_q;
  logic        lost_q;

  assign acq_inc  = acq_cnt_q + AW'(1);
  assign good_inc = good_cnt_q + GW'(1);

  always_comb begin
    state_d    = state_q;
    acq_cnt_d  = acq_cnt_q;
    good_cnt_d = good_cnt_q;
    step_d     = step_q;
    unique case (state_q)
      LOSS_OF_SYNC: begin
        if (good_comma) begin
          state_d   = ACQUIRE;
          acq_cnt_d = AW'(1);
        end
      end
      ACQUIRE: begin
        if (bad) begin
          state_d   = LOSS_OF_SYNC;
          acq_cnt_d = '0;
        end else if (good_comma) begin
          if (acq_inc == AW'(g_comma_count)) begin
            state_d    = SYNC_ACQ;
            acq_cnt_d  = '0;
            step_d     = '0;
            good_cnt_d = '0;
          end else begin
            acq_cnt_d = acq_inc;
          end
        end
      end
      SYNC_ACQ: begin
        if (bad) begin
          good_cnt_d = '0;
          if (step_q == SW'(g_bad_limit)) begin
            state_d = LOSS_OF_SYNC;
            step_d  = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end else if (step_q != '0) begin
          // Enough consecutive good words undo one bad step
          if (good_inc == GW'(g_good_recover)) begin
            step_d     = step_q - SW'(1);
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      default: begin
        state_d    = LOSS_OF_SYNC;
        acq_cnt_d  = '0;
        good_cnt_d = '0;
        step_d     = '0;
      end
    endcase
  end

  assign lost = (state_q != LOSS_OF_SYNC) &&
                (state_d == LOSS_OF_SYNC);

  always_ff @(posedge clk_ref_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= LOSS_OF_SYNC;
      acq_cnt_q  <= '0;
      good_cnt_q <= '0;
      step_q     <= '0;
      rx_data_q  <= '0;
      rx_k_q     <= '0;
      valid_q    <= 1'b0;
      synced_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acq_cnt_q  <= acq_cnt_d;
      good_cnt_q <= good_cnt_d;
      step_q     <= step_d;
      rx_data_q  <= rx_data_i;
      rx_k_q     <= rx_k_i;
      valid_q    <= (state_d == SYNC_ACQ) & !bad;
      synced_q   <= (state_d == SYNC_ACQ);
      lost_q     <= lost;
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_k_o        = rx_k_q;
  assign rx_valid_o    = valid_q;
  assign synced_o      = synced_q;
  assign sync_lost_p_o = lost_q;

`ifdef WR_RX_SYNC_STATS_EN
  logic [15:0] bad_cnt_q;
  logic [15:0] los_cnt_q;

  always_ff @(posedge clk_ref_i or posedge rst_i) begin
    if (rst_i) begin
      bad_cnt_q <= '0;
      los_cnt_q <= '0;
    end else begin
      if (bad && bad_cnt_q != 16'hFFFF)
        bad_cnt_q <= bad_cnt_q + 16'd1;
      if (lost && los_cnt_q != 16'hFFFF)
        los_cnt_q <= los_cnt_q + 16'd1;
    end
  end

  assign bad_cnt_o = bad_cnt_q;
  assign los_cnt_o = los_cnt_q;
`endif

endmodule

// File: tb/tb_wr_1000basex_rx_sync.sv
// Directed scoreboard bench for wr_1000basex_rx_sync.
// Define WR_RX_SYNC_STATS_EN to also exercise the counters.
module tb_wr_1000basex_rx_sync;

  logic        clk_ref_i = 1'b0;
  logic        rst_i     = 1'b0;
  logic [15:0] rx_data_i = '0;
  logic [1:0]  rx_k_i    = '0;
  logic        rx_enc_err_i = 1'b0;
  logic [15:0] rx_data_o;
  logic [1:0]  rx_k_o;
  logic        rx_valid_o;
  logic        synced_o;
  logic        sync_lost_p_o;
`ifdef WR_RX_SYNC_STATS_EN
  logic [15:0] bad_cnt_o;
  logic [15:0] los_cnt_o;
`endif

  wr_1000basex_rx_sync dut (
    .clk_ref_i     (clk_ref_i),
    .rst_i         (rst_i),
    .rx_data_i     (rx_data_i),
    .rx_k_i        (rx_k_i),
    .rx_enc_err_i  (rx_enc_err_i),
    .rx_data_o     (rx_data_o),
    .rx_k_o        (rx_k_o),
    .rx_valid_o    (rx_valid_o),
    .synced_o      (synced_o),
    .sync_lost_p_o (sync_lost_p_o)
`ifdef WR_RX_SYNC_STATS_EN
    ,
    .bad_cnt_o     (bad_cnt_o),
    .los_cnt_o     (los_cnt_o)
`endif
  );

  always #5 clk_ref_i = ~clk_ref_i;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic        v;
    logic        s;
    logic        p;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word, queue its expected output, compare 1 clk later
  task automatic word(input string tag,
                      input logic [15:0] d, input logic [1:0] k,
                      input logic e, input logic v,
                      input logic s, input logic p);
    exp_t x;
    rx_data_i    = d;
    rx_k_i       = k;
    rx_enc_err_i = e;
    sb.push_back('{d: d, k: k, v: v, s: s, p: p});
    @(posedge clk_ref_i);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_data"},   {16'd0, rx_data_o},     {16'd0, x.d});
      chk({tag, "_k"},      {30'd0, rx_k_o},        {30'd0, x.k});
      chk({tag, "_valid"},  {31'd0, rx_valid_o},    {31'd0, x.v});
      chk({tag, "_synced"}, {31'd0, synced_o},      {31'd0, x.s});
      chk({tag, "_pulse"},  {31'd0, sync_lost_p_o}, {31'd0, x.p});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},   {16'd0, rx_data_o},     32'd0);
    chk({tag, "_k"},      {30'd0, rx_k_o},        32'd0);
    chk({tag, "_valid"},  {31'd0, rx_valid_o},    32'd0);
    chk({tag, "_synced"}, {31'd0, synced_o},      32'd0);
    chk({tag, "_pulse"},  {31'd0, sync_lost_p_o}, 32'd0);
`ifdef WR_RX_SYNC_STATS_EN
    chk({tag, "_badcnt"}, {16'd0, bad_cnt_o},     32'd0);
    chk({tag, "_loscnt"}, {16'd0, los_cnt_o},     32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk_all_zero("rst");
    @(negedge clk_ref_i);
    rst_i = 1'b0;
  endtask

  localparam logic [15:0] IDLE = 16'hBC50;
  localparam logic [15:0] DAT  = 16'h1234;

  initial begin
    #2;
    do_reset();

    // Acquire: sync and valid on the 3rd comma's output
    word("acq1", IDLE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("acq2", IDLE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("acq3", IDLE, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    word("sync", IDLE, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    // Single coding error then recovery back to step 0
    word("err",  IDLE, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      word("rec", IDLE, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    // Four bad words of different kinds: 4th loses sync
    word("bad1", DAT,      2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    word("bad2", 16'h50BC, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    word("bad3", 16'h5050, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    word("bad4", DAT,      2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    word("los",  DAT,      2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Odd-byte comma while acquiring
    word("oa1", IDLE,     2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("oa2", IDLE,     2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("oa3", 16'h50BC, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    word("oa4", DAT,      2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Good data while acquiring holds the comma count
    word("h1", IDLE,     2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("h2", DAT,      2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    word("h3", 16'hFB50, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("h4", IDLE,     2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("h5", IDLE,     2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    // One bad word per five keeps sync indefinitely
    for (int i = 0; i < 100; i++) begin
      if (i % 5 == 0)
        word("alt", IDLE, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
      else
        word("alt", DAT, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Partial recovery: 3 goods do not undo a step, 4 do
    word("pr_b1", DAT, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      word("pr_g3", DAT, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    word("pr_b2", DAT, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      word("pr_g4", DAT, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    word("pr_b3", DAT, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    word("pr_b4", DAT, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    word("pr_b5", DAT, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Async reset while synced: outputs drop at once, no pulse
    word("ra1", IDLE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("ra2", IDLE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("ra3", IDLE, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    word("ra4", IDLE, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    word("ra5", DAT,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef WR_RX_SYNC_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++)
      word("st_los", DAT, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("st_bad5", {16'd0, bad_cnt_o}, 32'd5);
    chk("st_los0", {16'd0, los_cnt_o}, 32'd0);
    for (int i = 0; i < 3; i++)
      word("st_acq", IDLE, 2'b10, 1'b0, i == 2, i == 2, 1'b0);
    for (int i = 0; i < 4; i++)
      word("st_bad", DAT, 2'b00, 1'b1, 1'b0, i != 3, i == 3);
    chk("st_bad9", {16'd0, bad_cnt_o}, 32'd9);
    chk("st_los1", {16'd0, los_cnt_o}, 32'd1);
    rx_data_i    = DAT;
    rx_k_i       = 2'b00;
    rx_enc_err_i = 1'b1;
    repeat (70000) @(posedge clk_ref_i);
    #1;
    chk("st_sat",   {16'd0, bad_cnt_o}, 32'h0000FFFF);
    chk("st_los1b", {16'd0, los_cnt_o}, 32'd1);
    do_reset();
    rx_enc_err_i = 1'b0;
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
